// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
//   state_e : arbiter FSM states (IDLE, BUSY)
//   NUM_REQ : number of requesters
//   SEL_W   : width of the mux select / requester index
//   onehot  : index -> one-hot grant vector
package arb_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Convert a requester index into its one-hot grant vector.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] i);
    return NUM_REQ'(1) << i;
  endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between requesting units and the arbiter.
//   req     : level-sensitive request lines, one per requester
//   done    : current holder ends its transfer this cycle
//   grant   : one-hot grant, all-zero when idle
//   sel     : 4:1 mux select, index of the granted requester
//   busy    : a grant is active
//   timeout : one-cycle pulse after a watchdog-forced release
// master = requester side, slave = arbiter side.
interface rr_arbiter4_if;
  import arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [NUM_REQ-1:0] grant;
  logic [SEL_W-1:0]   sel;
  logic               busy;
  logic               timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  sel,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output sel,
    output busy,
    output timeout
  );

endinterface

// File: rtl/rr_pick4.sv
// Combinational round-robin pick among four requesters.
//   req   : request vector
//   ptr   : index of the last granted requester
//   idx   : first set request scanning ptr+1, ptr+2, ptr+3, ptr (mod 4)
//   valid : at least one request is set
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   idx,
  output logic               valid
);

  logic [SEL_W-1:0]   start;
  logic [NUM_REQ-1:0] rot;
  logic [SEL_W-1:0]   off;

  // Rotate so the slot after ptr lands at bit 0, priority-encode, un-rotate.
  always_comb begin
    start = ptr + SEL_W'(1);
    rot   = '0;
    off   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rot[i] = req[SEL_W'(start + SEL_W'(i))];
    end
    // Descending scan so the lowest set rotated bit wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = SEL_W'(i);
      end
    end
    idx   = SEL_W'(start + off);
    valid = |req;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter sharing one 4:1 mux-selected resource among four
// requesters. A grant is held until the holder signals done, drops its
// request, or the hold watchdog expires; there is always at least one idle
// cycle between owners so the mux path settles.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : request/grant bundle (slave side)
// Parameter HOLD_MAX: max cycles a grant may be held; 0 disables the watchdog.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic         clk,
  input  logic         reset,
  rr_arbiter4_if.slave bus
);

  localparam int unsigned CNT_W   = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
  localparam int unsigned EXP_VAL = (HOLD_MAX == 0) ? 0 : HOLD_MAX - 1;
  localparam logic [CNT_W-1:0] CNT_EXP = CNT_W'(EXP_VAL);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_BUSY = BUSY;

  logic [0:0]         state_q,   state_d;
  logic [NUM_REQ-1:0] grant_q,   grant_d;
  logic [SEL_W-1:0]   sel_q,     sel_d;
  logic               busy_q,    busy_d;
  logic               timeout_q, timeout_d;
  logic [SEL_W-1:0]   ptr_q,     ptr_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;

  logic [SEL_W-1:0]   pick_idx;
  logic               pick_valid;
  logic               rel_normal_c;
  logic               rel_wd_c;

  rr_pick4 u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Release conditions for the current holder.
  always_comb begin
    rel_normal_c = bus.done || !bus.req[sel_q];
    rel_wd_c     = (HOLD_MAX != 0) && (cnt_q == CNT_EXP);
  end

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_BUSY;
          grant_d = onehot(pick_idx);
          sel_d   = pick_idx;
          busy_d  = 1'b1;
          ptr_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      ST_BUSY: begin
        if (rel_normal_c || rel_wd_c) begin
          state_d   = ST_IDLE;
          grant_d   = '0;
          busy_d    = 1'b0;
          // Only a release caused solely by the watchdog is flagged.
          timeout_d = rel_wd_c && !rel_normal_c;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; ptr resets to 3 so req[0] wins first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      sel_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= SEL_W'(3);
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.sel     = sel_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed testbench for rr_arbiter4 (HOLD_MAX=16 and HOLD_MAX=0 instances)
// and the standalone rr_pick4 picker.
module tb_rr_arbiter4;
  import arb_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  rr_arbiter4_if bus ();
  rr_arbiter4_if bus0 ();

  rr_arbiter4 #(.HOLD_MAX(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  rr_arbiter4 #(.HOLD_MAX(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  logic [3:0] p_req;
  logic [1:0] p_ptr;
  logic [1:0] p_idx;
  logic       p_valid;

  rr_pick4 u_pick (
    .req   (p_req),
    .ptr   (p_ptr),
    .idx   (p_idx),
    .valid (p_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    bus.req   = 4'b0000;
    bus.done  = 1'b0;
    bus0.req  = 4'b0000;
    bus0.done = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_pick_all();
    logic [1:0] e_idx;
    logic       found;
    logic [1:0] c;
    for (int r = 0; r < 16; r++) begin
      for (int p = 0; p < 4; p++) begin
        p_req = 4'(r);
        p_ptr = 2'(p);
        #1;
        e_idx = 2'd0;
        found = 1'b0;
        for (int j = 1; j <= 4; j++) begin
          c = 2'((p + j) % 4);
          if (!found && p_req[c]) begin
            e_idx = c;
            found = 1'b1;
          end
        end
        checks++;
        if (p_valid !== (r != 0) || (found && p_idx !== e_idx)) begin
          errors++;
          $display("FAIL pick req=%b ptr=%0d: idx=%0d valid=%b, expected idx=%0d valid=%b",
                   p_req, p, p_idx, p_valid, e_idx, found);
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.grant !== 4'b0000 || bus.sel !== 2'd0 || bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: grant=%b sel=%0d busy=%b timeout=%b, expected 0000/0/0/0",
               bus.grant, bus.sel, bus.busy, bus.timeout);
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.req = 4'b0001;
    tick();
    checks++;
    if (bus.grant !== 4'b0001 || bus.sel !== 2'd0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: grant=%b sel=%0d busy=%b, expected 0001/0/1",
               bus.grant, bus.sel, bus.busy);
    end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.req  = 4'b0000;
    checks++;
    if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL single_done: grant=%b busy=%b timeout=%b, expected 0000/0/0",
               bus.grant, bus.busy, bus.timeout);
    end
    // done in IDLE has no effect
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.grant !== 4'b0000 || bus.sel !== 2'd0) begin
      errors++;
      $display("FAIL idle_done: grant=%b sel=%0d busy=%b, expected 0000/0/0",
               bus.grant, bus.sel, bus.busy);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] exp_s [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (bus.grant !== exp_g[k] || bus.sel !== exp_s[k] || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL rotation_grant[%0d]: grant=%b sel=%0d busy=%b, expected %b/%0d/1",
                 k, bus.grant, bus.sel, bus.busy, exp_g[k], exp_s[k]);
      end
      bus.done = 1'b1;
      tick();
      bus.done = 1'b0;
      checks++;
      if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.sel !== exp_s[k]) begin
        errors++;
        $display("FAIL rotation_idle[%0d]: grant=%b sel=%0d busy=%b, expected 0000/%0d/0",
                 k, bus.grant, bus.sel, bus.busy, exp_s[k]);
      end
    end
    bus.req = 4'b0000;
    tick();
  endtask

  task automatic test_watchdog();
    do_reset();
    bus.req = 4'b0100;
    tick();
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (bus.grant !== 4'b0100 || bus.sel !== 2'd2 || bus.timeout !== 1'b0) begin
        errors++;
        $display("FAIL wd_hold[%0d]: grant=%b sel=%0d timeout=%b, expected 0100/2/0",
                 k, bus.grant, bus.sel, bus.timeout);
      end
      tick();
    end
    checks++;
    if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.timeout !== 1'b1) begin
      errors++;
      $display("FAIL wd_release: grant=%b busy=%b timeout=%b, expected 0000/0/1",
               bus.grant, bus.busy, bus.timeout);
    end
    tick();
    checks++;
    if (bus.grant !== 4'b0100 || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL wd_regrant: grant=%b timeout=%b, expected 0100/0",
               bus.grant, bus.timeout);
    end
    bus.req = 4'b0000;
    tick();
  endtask

  task automatic test_done_at_expiry();
    do_reset();
    bus.req = 4'b0100;
    tick();
    for (int k = 0; k < 15; k++) tick();
    checks++;
    if (bus.grant !== 4'b0100) begin
      errors++;
      $display("FAIL expiry_prehold: grant=%b, expected 0100", bus.grant);
    end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    bus.req  = 4'b0000;
    checks++;
    if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL expiry_done: grant=%b busy=%b timeout=%b, expected 0000/0/0",
               bus.grant, bus.busy, bus.timeout);
    end
    tick();
    checks++;
    if (bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL expiry_done_late: timeout=%b, expected 0", bus.timeout);
    end
  endtask

  task automatic test_drop_req();
    do_reset();
    bus.req = 4'b0010;
    tick();
    tick();
    checks++;
    if (bus.grant !== 4'b0010 || bus.sel !== 2'd1) begin
      errors++;
      $display("FAIL drop_hold: grant=%b sel=%0d, expected 0010/1", bus.grant, bus.sel);
    end
    bus.req = 4'b0000;
    tick();
    checks++;
    if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.timeout !== 1'b0) begin
      errors++;
      $display("FAIL drop_release: grant=%b busy=%b timeout=%b, expected 0000/0/0",
               bus.grant, bus.busy, bus.timeout);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.req = 4'b1000;
    tick();
    checks++;
    if (bus.grant !== 4'b1000 || bus.sel !== 2'd3 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: grant=%b sel=%0d busy=%b, expected 1000/3/1",
               bus.grant, bus.sel, bus.busy);
    end
    reset = 1'b0;
    #2;
    checks++;
    if (bus.grant !== 4'b0000 || bus.sel !== 2'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL areset_async: grant=%b sel=%0d busy=%b, expected 0000/0/0",
               bus.grant, bus.sel, bus.busy);
    end
    tick();
    reset   = 1'b1;
    bus.req = 4'b1001;
    tick();
    checks++;
    if (bus.grant !== 4'b0001 || bus.sel !== 2'd0) begin
      errors++;
      $display("FAIL areset_ptr: grant=%b sel=%0d, expected 0001/0", bus.grant, bus.sel);
    end
    bus.req = 4'b0000;
    tick();
  endtask

  task automatic test_no_watchdog();
    int bad;
    do_reset();
    bus0.req = 4'b0001;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      checks++;
      if (bus0.grant !== 4'b0001 || bus0.timeout !== 1'b0 || bus0.busy !== 1'b1) begin
        errors++;
        bad++;
        if (bad <= 3)
          $display("FAIL nowd_hold[%0d]: grant=%b timeout=%b busy=%b, expected 0001/0/1",
                   k, bus0.grant, bus0.timeout, bus0.busy);
      end
    end
    bus0.req = 4'b0000;
    tick();
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    bad = 0;
    for (int k = 0; k < 10000; k++) begin
      bus.req  = 4'($urandom_range(0, 15));
      bus.done = ($urandom_range(0, 3) == 0);
      tick();
      checks++;
      if (!$onehot0(bus.grant) || (bus.busy !== (|bus.grant)) ||
          (bus.busy && bus.grant !== onehot(bus.sel)) ||
          (bus.timeout && bus.busy)) begin
        errors++;
        bad++;
        if (bad <= 3)
          $display("FAIL random_invariant[%0d]: grant=%b sel=%0d busy=%b timeout=%b",
                   k, bus.grant, bus.sel, bus.busy, bus.timeout);
      end
    end
    bus.req  = 4'b0000;
    bus.done = 1'b0;
    tick();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    bus.req   = 4'b0000;
    bus.done  = 1'b0;
    bus0.req  = 4'b0000;
    bus0.done = 1'b0;
    p_req     = 4'b0000;
    p_ptr     = 2'd0;
    test_pick_all();
    test_reset();
    test_single();
    test_rotation();
    test_watchdog();
    test_done_at_expiry();
    test_drop_req();
    test_async_reset();
    test_no_watchdog();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Round-robin scheduler that shares one 4-input datapath resource (a 4:1 mux-selected bus, e.g. a shared memory/register write port) among four requesters.
- Produces a registered 2-bit select for the 4:1 mux and a matching one-hot grant.
- Holds each grant until the owner signals completion, drops its request, or a watchdog expires.
- Sits between requesting units and the mux select input in the CPU datapath.

Parameters:
HOLD_MAX, 16, maximum cycles a grant may be held before forced release; 0 disables the watchdog.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-low reset (0 = in reset).
req  input  4  request lines, one per requester, level-sensitive.
done  input  1  current grant holder ends its transfer this cycle.
grant  output  4  one-hot grant, registered; all-zero when idle.
sel  output  2  registered mux select = index of granted requester.
busy  output  1  1 while a grant is active.
timeout  output  1  one-cycle pulse on a watchdog-forced release.

Behaviour:
- Reset (async assert, sync to clk on deassert): grant=0000, sel=00, busy=0, timeout=0, state=IDLE, hold counter=0, last-grant pointer ptr=3 (so req[0] has top priority after reset).
- States: IDLE, BUSY.
- IDLE:
  - If req!=0, pick the first set bit scanning ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - Next edge: grant=onehot(idx), sel=idx, busy=1, ptr=idx, counter=0, go BUSY.
  - Latency: req rising in cycle N -> grant visible after edge N+1.
  - If req=0, stay IDLE; sel retains its last value.
- BUSY (holder h=sel):
  - Release conditions, evaluated each cycle: done=1; req[h]=0; or HOLD_MAX!=0 and counter==HOLD_MAX-1.
  - On release at edge: grant=0000, busy=0, go IDLE; sel unchanged.
  - Otherwise counter increments (width clog2(HOLD_MAX+1), never wraps).
- Turnaround: release edge to IDLE, arbitrate in IDLE, new grant one edge later. Minimum 1 dead cycle between owners so the 4:1 mux path (about 300 ps) settles before the next owner drives.
- timeout: pulses high for exactly the cycle after a watchdog-only release.
  - If done=1 or req[h]=0 in the same cycle as expiry, the release is normal and timeout stays 0.
- done while IDLE is ignored.
- Requests from non-holders during BUSY are not latched; they are arbitrated only from live req in IDLE.
- Fairness: a requester that keeps req high is granted within 3 other grants.
- Reset asserted mid-grant: all outputs return to reset values immediately (asynchronous), ptr returns to 3.
- Invariants: grant is one-hot or zero; grant==onehot(sel) whenever busy=1; busy==|grant.

Decomposition:
- Shared package arb_pkg:
  - state enum {IDLE, BUSY}
  - NUM_REQ=4
  - SEL_W=2
- Sub-module rr_pick4 (combinational):
  - inputs: req[3:0], ptr[1:0]
  - outputs: idx[1:0], valid
  - rotate, priority-encode, un-rotate
  - Unit-testable on its own with all 64 req/ptr combinations.

Test Plan:
- Reset, then req=0001 -> grant=0001, sel=00, busy=1 one cycle later. done=1 for one cycle -> grant=0000, busy=0 next cycle, timeout=0.
- req=1111 held, done pulsed one cycle after each grant -> grant sequence 0001,0010,0100,1000,0001 with one idle cycle between each.
- HOLD_MAX=16, req=0100 held, done=0 -> grant held 16 cycles, then released. timeout=1 for exactly one cycle; req still high -> regranted 0100 after the idle cycle.
- done=1 on the exact expiry cycle -> release occurs, timeout stays 0. Separately, holder drops req (req 0010->0000) mid-grant -> release next edge, timeout=0.
- Assert reset while grant=1000, busy=1 -> grant=0000, sel=00, busy=0 without a clock edge. After deassert, req=1001 -> grant=0001 (ptr reset to 3).
- HOLD_MAX=0, req=0001 held 100 cycles, done=0 -> grant never released, timeout never asserts. Randomized req/done over 10k cycles with one-hot and grant/sel consistency assertions.
